pair_sum_accum: RTL and testbench
=================================

// Module: pair_sum_accum
// PURPOSE
//  Downstream consumer of the 2-bit pair adder's 3-bit sums (range 0..6).
//  Accepts one sum per valid/ready handshake, accumulates COUNT sums per frame
//  into a wide total, then presents the frame total on a valid/ready output.
//  Sits between the pair adder and any frame-level consumer; the adder itself
//  stays purely combinational.
// PARAMETERS
//  COUNT  4  sums per frame; legal range 1..255
//  ACC_W  8  accumulator/total width in bits; legal range 3..32
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  clear      in   1      synchronous frame abort; highest priority after reset
//  in_valid   in   1      in_sum is valid this cycle
//  in_ready   out  1      block can accept in_sum this cycle
//  in_sum     in   3      pair-adder result; raw 3-bit value, 7 accumulated as 7
//  out_valid  out  1      out_total/out_ovf valid
//  out_ready  in   1      downstream takes the total this cycle
//  out_total  out  ACC_W  frame sum, modulo 2^ACC_W
//  out_ovf    out  1      frame sum exceeded 2^ACC_W-1 (sticky within frame)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=ACCUM, acc=0, cnt=0, ovf=0; outputs
//    in_ready=0 while rst_n low, out_valid=0, out_total=0, out_ovf=0 immediately.
//  - States: ACCUM, DONE. in_ready = (state==ACCUM) && rst_n; registered state
//    only, no combinational path from out_ready or in_valid to in_ready.
//  - ACCUM: on in_valid&in_ready: {carry,acc} = acc + in_sum (zero-extended);
//    ovf |= carry; cnt++. No handshake -> no change (bubbles do not count).
//  - When accept makes cnt==COUNT: next cycle state=DONE, out_valid=1,
//    out_total=final acc incl. that sum, out_ovf=final ovf. Latency: out_valid
//    rises on the edge that captures the COUNT-th sum (visible next cycle).
//  - DONE: out_total/out_ovf held stable while out_valid=1 and out_ready=0;
//    in_ready=0, in_sum ignored. On out_valid&out_ready: acc=0, cnt=0, ovf=0,
//    state=ACCUM, out_valid=0 next cycle; in_ready=1 next cycle (1 bubble/frame).
//  - out_total/out_ovf read 0 whenever out_valid=0 (driven from a cleared
//    output register, not from the live accumulator).
//  - clear=1 (any state): next cycle acc=0, cnt=0, ovf=0, state=ACCUM,
//    out_valid=0; a handshake coincident with clear is discarded (input sum
//    dropped; pending total dropped even if out_ready=1).
//  - COUNT=1: every accepted sum produces a frame; out_total = in_sum.
//  - Overflow: total wraps mod 2^ACC_W; out_ovf flags any carry-out in frame.
//  - Reset mid-frame: partial frame discarded, no output produced.
// TESTING
//  1. COUNT=4,ACC_W=8; sums 6,6,6,6 back-to-back -> out_valid 1 cycle after
//     4th accept, out_total=24, out_ovf=0; out_ready=1 -> in_ready back next cycle.
//  2. Frame of 1,2,3,0 done, hold out_ready=0 5 cycles with in_valid=1,in_sum=5
//     -> in_ready=0, out_total stays 6, no sums absorbed; then release -> next
//     frame starts at 0.
//  3. ACC_W=4; sums 6,6,6,6 -> out_total=8 (24 mod 16), out_ovf=1; following
//     frame 1,1,1,1 -> out_total=4, out_ovf=0 (flag cleared per frame).
//  4. in_valid pattern 1,0,0,1,0,1,1 with sums 2,x,x,3,x,4,5 -> out_total=14,
//     exactly 4 accepts counted.
//  5. clear after 2 accepts (5,5), then 1,1,1,1 -> out_total=4; clear while
//     out_valid=1 with out_ready=1 -> out_valid drops, total not re-presented.
//  6. rst_n low asynchronously mid-frame (between edges) -> out_valid,
//     in_ready, out_total go 0 before next edge; after release frame restarts.

Source files
------------

// File: rtl/pair_sum_accum.sv
// Frame accumulator for pair-adder sums: adds COUNT accepted sums, then holds
// the wrapped total and carry-out flag on a valid/ready output until taken.
module pair_sum_accum #(
    parameter int COUNT = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic             out_ovf
);

    typedef enum logic {
        ACCUM,
        DONE
    } state_t;

    localparam logic [7:0] LAST = 8'(COUNT - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] total_q, total_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             outOvf_q, outOvf_d;
    logic [ACC_W:0]   sumWide;

    // The top bit of the widened sum is the carry-out for this accept.
    assign sumWide   = {1'b0, acc_q} + {{(ACC_W-2){1'b0}}, in_sum};

    assign in_ready  = (state_q == ACCUM) && rst_n;
    assign out_valid = (state_q == DONE);
    assign out_total = total_q;
    assign out_ovf   = outOvf_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        total_d  = total_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        outOvf_d = outOvf_q;

        if (clear) begin
            state_d  = ACCUM;
            acc_d    = '0;
            total_d  = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            outOvf_d = 1'b0;
        end else if (state_q == ACCUM) begin
            if (in_valid) begin
                if (cnt_q == LAST) begin
                    // Final sum goes straight to the output register; the
                    // working accumulator restarts so the next frame begins at 0.
                    state_d  = DONE;
                    total_d  = sumWide[ACC_W-1:0];
                    outOvf_d = ovf_q | sumWide[ACC_W];
                    acc_d    = '0;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                end else begin
                    acc_d = sumWide[ACC_W-1:0];
                    ovf_d = ovf_q | sumWide[ACC_W];
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end else if (out_ready) begin
            state_d  = ACCUM;
            total_d  = '0;
            outOvf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ACCUM;
            acc_q    <= '0;
            total_q  <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            outOvf_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            total_q  <= total_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            outOvf_q <= outOvf_d;
        end
    end

endmodule

// File: tb/tb_pair_sum_accum.sv
// Directed bench for pair_sum_accum: a vector table for the main frame
// behaviour plus hand sequences for narrow accumulators, COUNT=1 and async reset.
module tb_pair_sum_accum;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       inValid;
    logic [2:0] inSum;
    logic       outReady;

    logic       inReady,  outValid,  outOvf;
    logic [7:0] outTotal;
    logic       inReady4, outValid4, outOvf4;
    logic [3:0] outTotal4;
    logic       inReady1, outValid1, outOvf1;
    logic [7:0] outTotal1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       v;
        logic [2:0] sum;
        logic       rdy;
        logic       clr;
        logic       expReady;
        logic       expValid;
        logic [7:0] expTotal;
        logic       expOvf;
    } vec_t;

    vec_t vecs[$];

    pair_sum_accum #(.COUNT(4), .ACC_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(inValid), .in_ready(inReady), .in_sum(inSum),
        .out_valid(outValid), .out_ready(outReady),
        .out_total(outTotal), .out_ovf(outOvf)
    );

    pair_sum_accum #(.COUNT(4), .ACC_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(inValid), .in_ready(inReady4), .in_sum(inSum),
        .out_valid(outValid4), .out_ready(outReady),
        .out_total(outTotal4), .out_ovf(outOvf4)
    );

    pair_sum_accum #(.COUNT(1), .ACC_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(inValid), .in_ready(inReady1), .in_sum(inSum),
        .out_valid(outValid1), .out_ready(outReady),
        .out_total(outTotal1), .out_ovf(outOvf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic applyStimulus(input logic v, input logic [2:0] s, input logic r, input logic c);
        inValid  = v;
        inSum    = s;
        outReady = r;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic v, input logic [2:0] s, input logic r, input logic c,
                          input logic eRdy, input logic eVal, input logic [7:0] eTot, input logic eOvf);
        vec_t t;
        t.v = v; t.sum = s; t.rdy = r; t.clr = c;
        t.expReady = eRdy; t.expValid = eVal; t.expTotal = eTot; t.expOvf = eOvf;
        vecs.push_back(t);
    endtask

    task automatic checkMain(input string tag, input logic eRdy, input logic eVal,
                             input logic [7:0] eTot, input logic eOvf);
        checkOutput({tag, " in_ready"},  {31'd0, inReady},  {31'd0, eRdy});
        checkOutput({tag, " out_valid"}, {31'd0, outValid}, {31'd0, eVal});
        checkOutput({tag, " out_total"}, {24'd0, outTotal}, {24'd0, eTot});
        checkOutput({tag, " out_ovf"},   {31'd0, outOvf},   {31'd0, eOvf});
    endtask

    // Assert reset between edges, check outputs before the next edge, then release.
    task automatic midCycleReset(input string tag);
        inValid  = 1'b0;
        outReady = 1'b0;
        clear    = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkMain(tag, 1'b0, 1'b0, 8'd0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; inValid = 1'b0; inSum = 3'd0; outReady = 1'b0;
        #2;
        checkMain("reset", 1'b0, 1'b0, 8'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkMain("after reset", 1'b1, 1'b0, 8'd0, 1'b0);

        // Back-to-back 6s, one-cycle release
        for (int i = 0; i < 3; i++) addVec(1, 3'd6, 0, 0, 1, 0, 8'd0, 0);
        addVec(1, 3'd6, 0, 0, 0, 1, 8'd24, 0);
        addVec(0, 3'd0, 1, 0, 1, 0, 8'd0, 0);
        // Bubbles are not counted: 2,-,-,3,-,4,5
        addVec(1, 3'd2, 0, 0, 1, 0, 8'd0, 0);
        addVec(0, 3'd7, 0, 0, 1, 0, 8'd0, 0);
        addVec(0, 3'd7, 0, 0, 1, 0, 8'd0, 0);
        addVec(1, 3'd3, 0, 0, 1, 0, 8'd0, 0);
        addVec(0, 3'd7, 0, 0, 1, 0, 8'd0, 0);
        addVec(1, 3'd4, 0, 0, 1, 0, 8'd0, 0);
        addVec(1, 3'd5, 0, 0, 0, 1, 8'd14, 0);
        addVec(0, 3'd0, 1, 0, 1, 0, 8'd0, 0);
        // Backpressure: held total, sums offered while DONE are not absorbed
        addVec(1, 3'd1, 0, 0, 1, 0, 8'd0, 0);
        addVec(1, 3'd2, 0, 0, 1, 0, 8'd0, 0);
        addVec(1, 3'd3, 0, 0, 1, 0, 8'd0, 0);
        addVec(1, 3'd0, 0, 0, 0, 1, 8'd6, 0);
        for (int i = 0; i < 5; i++) addVec(1, 3'd5, 0, 0, 0, 1, 8'd6, 0);
        addVec(1, 3'd5, 1, 0, 1, 0, 8'd0, 0);
        for (int i = 0; i < 3; i++) addVec(1, 3'd1, 0, 0, 1, 0, 8'd0, 0);
        addVec(1, 3'd1, 0, 0, 0, 1, 8'd4, 0);
        addVec(0, 3'd0, 1, 0, 1, 0, 8'd0, 0);
        // Clear mid-frame (coincident sum dropped), then clear while presenting
        addVec(1, 3'd5, 0, 0, 1, 0, 8'd0, 0);
        addVec(1, 3'd5, 0, 0, 1, 0, 8'd0, 0);
        addVec(1, 3'd5, 0, 1, 1, 0, 8'd0, 0);
        for (int i = 0; i < 3; i++) addVec(1, 3'd1, 0, 0, 1, 0, 8'd0, 0);
        addVec(1, 3'd1, 0, 0, 0, 1, 8'd4, 0);
        addVec(1, 3'd3, 1, 1, 1, 0, 8'd0, 0);
        addVec(0, 3'd0, 0, 0, 1, 0, 8'd0, 0);
        for (int i = 0; i < 3; i++) addVec(1, 3'd2, 0, 0, 1, 0, 8'd0, 0);
        addVec(1, 3'd2, 0, 0, 0, 1, 8'd8, 0);
        addVec(0, 3'd0, 1, 0, 1, 0, 8'd0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].v, vecs[i].sum, vecs[i].rdy, vecs[i].clr);
            checkMain($sformatf("row%0d", i), vecs[i].expReady, vecs[i].expValid,
                      vecs[i].expTotal, vecs[i].expOvf);
        end

        // 4-bit accumulator: 24 wraps to 8 with overflow, flag clears next frame
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 3'd6, 1'b0, 1'b0);
        checkOutput("w4 out_valid", {31'd0, outValid4}, 32'd1);
        checkOutput("w4 out_total", {28'd0, outTotal4}, 32'd8);
        checkOutput("w4 out_ovf",   {31'd0, outOvf4},   32'd1);
        checkOutput("w8 out_total", {24'd0, outTotal},  32'd24);
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        checkOutput("w4 released", {31'd0, outValid4}, 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 3'd1, 1'b0, 1'b0);
        checkOutput("w4 f2 out_total", {28'd0, outTotal4}, 32'd4);
        checkOutput("w4 f2 out_ovf",   {31'd0, outOvf4},   32'd0);
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);

        // Async reset while a total is being presented
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 3'd1, 1'b0, 1'b0);
        checkMain("pre-reset done", 1'b0, 1'b1, 8'd4, 1'b0);
        midCycleReset("reset in DONE");

        // Async reset with a partial frame of 3,3
        applyStimulus(1'b1, 3'd3, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd3, 1'b0, 1'b0);
        midCycleReset("reset mid-frame");

        // COUNT=1 instance frames every accept; main restarts from zero: 7+3+1+1
        applyStimulus(1'b1, 3'd7, 1'b0, 1'b0);
        checkOutput("c1 valid a", {31'd0, outValid1}, 32'd1);
        checkOutput("c1 total a", {24'd0, outTotal1}, 32'd7);
        applyStimulus(1'b1, 3'd3, 1'b1, 1'b0);
        checkOutput("c1 valid b", {31'd0, outValid1}, 32'd0);
        applyStimulus(1'b1, 3'd1, 1'b0, 1'b0);
        checkOutput("c1 valid c", {31'd0, outValid1}, 32'd1);
        checkOutput("c1 total c", {24'd0, outTotal1}, 32'd1);
        applyStimulus(1'b1, 3'd1, 1'b1, 1'b0);
        checkMain("post-reset frame", 1'b0, 1'b1, 8'd12, 1'b0);
        checkOutput("c1 valid d", {31'd0, outValid1}, 32'd0);
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        checkMain("final release", 1'b1, 1'b0, 8'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
